// File: rtl/mem_port_arbiter.sv
// Arbitrates one 64-bit memory bus port between instruction fetch and load/store.
// One transaction in flight at a time: LS has priority, bounded by an IF starvation guard and a response timeout.
module mem_port_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                arb_clk_i,
  input  logic                arb_rst_n_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_wmask_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                arb_err_o
);

  localparam int STRK_W = $clog2(STARVE_MAX + 1);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [STRK_W-1:0] STREAK_MAX = STRK_W'(STARVE_MAX);
  localparam logic [TCNT_W-1:0] TCNT_MAX   = TCNT_W'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  logic [STRK_W-1:0] streak, streak_nxt;
  logic [TCNT_W-1:0] tcnt, tcnt_nxt;
  logic              pick_ls;
  logic              finish;
  logic [DATA_W-1:0] rsp_data;

  // LS wins unless IF is waiting and has already lost STARVE_MAX times in a row.
  assign pick_ls = ls_req_i && !(if_req_i && (streak == STREAK_MAX));

  always_ff @(posedge arb_clk_i or negedge arb_rst_n_i) begin
    if (!arb_rst_n_i) begin
      state  <= ST_IDLE;
      owner  <= OWN_IF;
      streak <= '0;
      tcnt   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state  <= state_nxt;
      owner  <= owner_nxt;
      streak <= streak_nxt;
      tcnt   <= tcnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nxt   = state;
    owner_nxt   = owner;
    streak_nxt  = streak;
    tcnt_nxt    = '0;
    finish      = 1'b0;
    rsp_data    = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    if_gnt_o    = 1'b0;
    ls_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    ls_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    ls_rdata_o  = '0;
    arb_err_o   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pick_ls) begin
          owner_nxt = OWN_LS;
          state_nxt = ST_ISSUE;
        end else if (if_req_i) begin
          owner_nxt = OWN_IF;
          state_nxt = ST_ISSUE;
        end
        // An LS win over a waiting IF implies streak < STARVE_MAX, so the increment saturates naturally.
        if (pick_ls && if_req_i) streak_nxt = streak + STRK_W'(1);
        else                     streak_nxt = '0;
      end

      ST_ISSUE: begin
        mem_req_o = 1'b1;
        if (owner == OWN_LS) begin
          mem_we_o    = ls_we_i;
          mem_addr_o  = ls_addr_i;
          mem_wdata_o = ls_wdata_i;
          mem_wmask_o = ls_wmask_i;
          ls_gnt_o    = mem_gnt_i;
        end else begin
          mem_addr_o  = if_addr_i;
          if_gnt_o    = mem_gnt_i;
        end
        if (mem_gnt_i) begin
          state_nxt = ST_WAIT;
          tcnt_nxt  = TCNT_W'(1);
        end
      end

      ST_WAIT: begin
        // tcnt holds the 1-based index of the current WAIT cycle; a real response beats the abort.
        if (mem_rvalid_i) begin
          finish   = 1'b1;
          rsp_data = mem_rdata_i;
        end else if (tcnt == TCNT_MAX) begin
          finish    = 1'b1;
          arb_err_o = 1'b1;
        end
        if (finish) begin
          state_nxt = ST_IDLE;
          if (owner == OWN_LS) begin
            ls_rvalid_o = 1'b1;
            ls_rdata_o  = rsp_data;
          end else begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = rsp_data;
          end
        end else begin
          tcnt_nxt = tcnt + TCNT_W'(1);
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int DW = 64;
  localparam int AW = 64;
  localparam int STARVE = 4;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req_i, ls_req_i, ls_we_i;
  logic [AW-1:0] if_addr_i, ls_addr_i;
  logic [DW-1:0] ls_wdata_i, mem_rdata_i;
  logic [7:0]    ls_wmask_i;
  logic          mem_gnt_i, mem_rvalid_i;
  logic          if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o;
  logic [DW-1:0] if_rdata_o, ls_rdata_o, mem_wdata_o;
  logic          mem_req_o, mem_we_o, arb_err_o;
  logic [AW-1:0] mem_addr_o;
  logic [7:0]    mem_wmask_o;

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(STARVE), .TIMEOUT(TMO)) dut (
    .arb_clk_i(clk), .arb_rst_n_i(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_wmask_i(ls_wmask_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .arb_err_o(arb_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Knobs written only by the main sequence; the driver below owns req/gnt/rvalid.
  int if_posted = 0, ls_posted = 0, late_post = 0;
  int if_done = 0, ls_done = 0, late_done = 0;
  int gnt_delay = 0, rsp_delay = 0;
  string glog = "";

  // Requester + bus slave: requests stay up until granted; slave grants after gnt_delay
  // ISSUE cycles and answers in WAIT cycle rsp_delay+1 (never if rsp_delay < 0).
  initial begin : driver
    bit busy = 0;
    int req_cnt = 0, wcnt = 0;
    if_req_i = 0; ls_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0; req_cnt = 0; wcnt = 0;
        if_done = if_posted; ls_done = ls_posted; late_done = late_post;
      end else begin
        if (if_gnt_o) begin if_done++; glog = {glog, "I"}; end
        if (ls_gnt_o) begin ls_done++; glog = {glog, "L"}; end
        if (mem_req_o) begin
          if (mem_gnt_i) begin busy = 1; wcnt = 0; req_cnt = 0; end
          else req_cnt++;
        end else if (busy) begin
          if (mem_rvalid_i || arb_err_o) busy = 0;
          else wcnt++;
        end
      end
      @(posedge clk);
      #2;
      if_req_i     = rst_n && (if_posted > if_done);
      ls_req_i     = rst_n && (ls_posted > ls_done);
      mem_gnt_i    = mem_req_o && (req_cnt == gnt_delay);
      mem_rvalid_i = (busy && rsp_delay >= 0 && wcnt == rsp_delay) || (late_post > late_done);
      if (late_post > late_done) late_done++;
    end
  end

  // Transaction-level reference: one transaction record, a count of consecutive LS wins
  // over a waiting IF, and the WAIT-cycle age of the accepted transaction.
  initial begin : scoreboard
    bit m_active = 0, m_ls = 0, m_acc = 0;
    int m_wait = 0, m_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_active = 0; m_acc = 0; m_wait = 0; m_run = 0;
        check("rst_mem_req", mem_req_o, 0);
        check("rst_gnts", {if_gnt_o, ls_gnt_o}, 0);
        check("rst_rvalids", {if_rvalid_o, ls_rvalid_o, arb_err_o}, 0);
        check("rst_addr", mem_addr_o, 0);
      end else begin
        bit e_req, done, e_err;
        logic [63:0] rd;
        e_req = m_active && !m_acc;
        done  = m_active && m_acc && (mem_rvalid_i || m_wait == TMO);
        e_err = done && !mem_rvalid_i;
        rd    = mem_rvalid_i ? mem_rdata_i : 64'h0;
        check("mdl_mem_req", mem_req_o, e_req);
        check("mdl_mem_we", mem_we_o, e_req && m_ls && ls_we_i);
        check("mdl_mem_addr", mem_addr_o, !e_req ? 64'h0 : (m_ls ? ls_addr_i : if_addr_i));
        check("mdl_mem_wdata", mem_wdata_o, (e_req && m_ls) ? ls_wdata_i : 64'h0);
        check("mdl_mem_wmask", mem_wmask_o, (e_req && m_ls) ? ls_wmask_i : 8'h0);
        check("mdl_if_gnt", if_gnt_o, e_req && !m_ls && mem_gnt_i);
        check("mdl_ls_gnt", ls_gnt_o, e_req && m_ls && mem_gnt_i);
        check("mdl_if_rvalid", if_rvalid_o, done && !m_ls);
        check("mdl_ls_rvalid", ls_rvalid_o, done && m_ls);
        check("mdl_if_rdata", if_rdata_o, (done && !m_ls) ? rd : 64'h0);
        check("mdl_ls_rdata", ls_rdata_o, (done && m_ls) ? rd : 64'h0);
        check("mdl_err", arb_err_o, e_err);
        if (!m_active) begin
          if (ls_req_i && !(if_req_i && m_run == STARVE)) begin
            m_active = 1; m_ls = 1; m_acc = 0;
            m_run = if_req_i ? m_run + 1 : 0;
          end else if (if_req_i) begin
            m_active = 1; m_ls = 0; m_acc = 0; m_run = 0;
          end else begin
            m_run = 0;
          end
        end else if (!m_acc) begin
          if (mem_gnt_i) begin m_acc = 1; m_wait = 1; end
        end else if (done) begin
          m_active = 0;
        end else begin
          m_wait++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((if_posted != if_done || ls_posted != ls_done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_in_budget"}, n < budget, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_if_only(input string tag);
    gnt_delay = 0; rsp_delay = 0;
    if_addr_i = 64'h8000_0000; mem_rdata_i = 64'h1111_2222_3333_4444;
    tick(); if_posted++;
    @(negedge clk);
    check({tag, "_N_mem_req"}, mem_req_o, 0);
    @(negedge clk);
    check({tag, "_N1_mem_req"}, mem_req_o, 1);
    check({tag, "_N1_if_gnt"}, if_gnt_o, 1);
    check({tag, "_N1_addr"}, mem_addr_o, 64'h8000_0000);
    check({tag, "_N1_ls_gnt"}, ls_gnt_o, 0);
    @(negedge clk);
    check({tag, "_N2_if_rvalid"}, if_rvalid_o, 1);
    check({tag, "_N2_if_rdata"}, if_rdata_o, 64'h1111_2222_3333_4444);
    check({tag, "_N2_ls_rvalid"}, {ls_rvalid_o, ls_rdata_o}, 0);
    @(negedge clk);
    check({tag, "_N3_if_rvalid"}, if_rvalid_o, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst_n = 0;
    if_addr_i = 0; ls_addr_i = 0; ls_wdata_i = 0; ls_wmask_i = 0; ls_we_i = 0; mem_rdata_i = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {mem_req_o, if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o, arb_err_o}, 0);
    tick(); rst_n = 1;
    repeat (2) @(negedge clk);

    // IF alone: request at N, bus request + grant at N+1, data at N+2.
    run_if_only("t1");

    // Simultaneous requests: LS write first, IF in the following arbitration.
    ls_we_i = 1; ls_addr_i = 64'h1000; ls_wdata_i = 64'hDEAD_BEEF_0000_5555; ls_wmask_i = 8'h0F;
    if_addr_i = 64'h8000_0008;
    tick(); if_posted++; ls_posted++;
    @(negedge clk);
    @(negedge clk);
    check("t2_ls_gnt", ls_gnt_o, 1);
    check("t2_if_gnt", if_gnt_o, 0);
    check("t2_we", mem_we_o, 1);
    check("t2_wmask", mem_wmask_o, 8'h0F);
    check("t2_addr", mem_addr_o, 64'h1000);
    @(negedge clk);
    check("t2_ls_ack", ls_rvalid_o, 1);
    @(negedge clk);
    @(negedge clk);
    check("t2_if_gnt_next", if_gnt_o, 1);
    check("t2_if_we_mask", {mem_we_o, mem_wmask_o}, 0);
    check("t2_if_addr", mem_addr_o, 64'h8000_0008);
    drain("t2", 40);

    // Starvation: LS continuous, IF held until granted.
    glog = ""; ls_we_i = 0;
    tick(); if_posted++; ls_posted += 6;
    drain("t3", 100);
    n_checks++;
    if (glog != "LLLLILL") begin
      n_fail++;
      $display("FAIL t3_grant_order: got %s, expected LLLLILL", glog);
    end

    // Timeout on an LS read with no response; a late response is ignored.
    rsp_delay = -1; mem_rdata_i = 64'hCAFE_F00D_CAFE_F00D; ls_addr_i = 64'h2000;
    tick(); ls_posted++;
    @(negedge clk);
    @(negedge clk);
    check("t4_ls_gnt", ls_gnt_o, 1);
    for (int i = 1; i <= TMO; i++) begin
      @(negedge clk);
      if (i < TMO) begin
        check("t4_wait_no_err", {arb_err_o, ls_rvalid_o}, 0);
      end else begin
        check("t4_abort_err", arb_err_o, 1);
        check("t4_abort_rvalid", ls_rvalid_o, 1);
        check("t4_abort_rdata", ls_rdata_o, 0);
      end
    end
    tick(); late_post++;
    repeat (3) begin
      @(negedge clk);
      check("t4_late_ignored", {ls_rvalid_o, if_rvalid_o, arb_err_o}, 0);
    end

    // Reset while a response is being delivered in WAIT: outputs clear at once.
    gnt_delay = 0; rsp_delay = 1; mem_rdata_i = 64'h5A5A_5A5A_5A5A_5A5A; if_addr_i = 64'h8000_0040;
    tick(); if_posted++;
    repeat (4) @(negedge clk);
    check("t5_pre_rst_rvalid", if_rvalid_o, 1);
    #1 rst_n = 0;
    #1;
    check("t5_async_rvalid", {if_rvalid_o, if_rdata_o}, 0);
    check("t5_async_bus", {mem_req_o, if_gnt_o, ls_gnt_o, arb_err_o}, 0);
    repeat (2) @(negedge clk);
    tick(); rst_n = 1;
    repeat (2) @(negedge clk);
    run_if_only("t5_after");

    // Back-pressure: grant withheld for 5 ISSUE cycles.
    gnt_delay = 5; rsp_delay = 0;
    ls_we_i = 1; ls_addr_i = 64'h3000; ls_wdata_i = 64'h0123_4567_89AB_CDEF; ls_wmask_i = 8'hF0;
    tick(); ls_posted++;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_hold_req", mem_req_o, 1);
      check("t6_hold_addr", mem_addr_o, 64'h3000);
      check("t6_hold_wdata", mem_wdata_o, 64'h0123_4567_89AB_CDEF);
      check("t6_hold_no_gnt", ls_gnt_o, 0);
    end
    @(negedge clk);
    check("t6_gnt", ls_gnt_o, 1);
    @(negedge clk);
    check("t6_ack", ls_rvalid_o, 1);
    drain("t6", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
